// File: rtl/mem_port_arbiter.sv
// Multi-channel cache-line memory port arbiter: arbitrates NUM_CH channels onto a
// single memory port with a three-state IDLE/MEM/RESP handshake and registered outputs.
module mem_port_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int ARB_MODE = 0,
  localparam int GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg;
  logic [GW-1:0]       grant_reg;
  logic [GW-1:0]       last_grant_reg;
  logic                mem_read_reg;
  logic                mem_write_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [LINE_W-1:0]   mem_wdata_reg;
  logic [LINE_W-1:0]   ch_rdata_reg;
  logic [NUM_CH-1:0]   ch_ready_reg;

  logic [NUM_CH-1:0]   req;
  logic                any_req;
  logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
  logic [LINE_W-1:0]   wdata_arr [NUM_CH];

  logic [GW-1:0]       win_idx;
  logic                win_write;
  logic [ADDR_W-1:0]   win_addr;
  logic [LINE_W-1:0]   win_wdata;
  int                  start_i;
  int                  dist_i;
  int                  best_dist;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = ch_wdata[gi*LINE_W +: LINE_W];
    end
  endgenerate

  assign req     = ch_read | ch_write;
  assign any_req = |req;

  // Winner = requesting channel at the smallest circular distance from the search
  // start; fixed priority is simply a search that always starts at channel 0.
  always_comb begin
    start_i   = (ARB_MODE == 1) ? 0 : int'(last_grant_reg) + 1;
    if (start_i >= NUM_CH) start_i = 0;
    best_dist = NUM_CH;
    dist_i    = 0;
    win_idx   = '0;
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dist_i = i - start_i;
      if (dist_i < 0) dist_i = dist_i + NUM_CH;
      if (req[i] && (dist_i < best_dist)) begin
        best_dist = dist_i;
        win_idx   = GW'(i);
        win_write = ch_write[i];
        win_addr  = addr_arr[i];
        win_wdata = wdata_arr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_CH - 1);
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      ch_rdata_reg   <= '0;
      ch_ready_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ch_ready_reg <= '0;
          if (any_req) begin
            grant_reg     <= win_idx;
            mem_addr_reg  <= win_addr;
            mem_wdata_reg <= win_wdata;
            // A simultaneous read+write request is served as a write.
            mem_write_reg <= win_write;
            mem_read_reg  <= ~win_write;
            if (ARB_MODE == 0) last_grant_reg <= win_idx;
            state_reg     <= MEM;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (mem_read_reg) ch_rdata_reg <= mem_rdata;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            ch_ready_reg  <= NUM_CH'(1) << grant_reg;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          ch_ready_reg <= '0;
          state_reg    <= IDLE;
        end
        default: begin
          ch_ready_reg  <= '0;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign ch_rdata  = ch_rdata_reg;
  assign ch_ready  = ch_ready_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign grant_id  = grant_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, SHALL set the number of cache-side channels (legal 1..8).
REQ-002 Parameter ADDR_W, default 28, SHALL set the line-address width (byte address bits [31:4]).
REQ-003 Parameter LINE_W, default 128, SHALL set the cache-line data width.
REQ-004 Parameter ARB_MODE, default 0, SHALL select the arbitration mode: 0 = round-robin, 1 = fixed priority with ch0 highest.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous assertion, active-low.
REQ-007 Port ch_read, input, NUM_CH bits, SHALL be the per-channel line-read request.
REQ-008 Port ch_write, input, NUM_CH bits, SHALL be the per-channel line-write request.
REQ-009 Port ch_addr, input, NUM_CH*ADDR_W bits, SHALL carry the channel addresses, channel i in bits [i*ADDR_W +: ADDR_W].
REQ-010 Port ch_wdata, input, NUM_CH*LINE_W bits, SHALL carry the channel write lines, packed the same way.
REQ-011 Port ch_rdata, output, LINE_W bits, SHALL be the read line, shared by all channels.
REQ-012 Port ch_ready, output, NUM_CH bits, SHALL be the per-channel completion strobe.
REQ-013 Ports mem_read and mem_write, outputs, 1 bit each, SHALL be the memory-side requests.
REQ-014 Port mem_addr, output, ADDR_W bits, SHALL be the memory-side line address.
REQ-015 Port mem_wdata, output, LINE_W bits, SHALL be the memory-side write line.
REQ-016 Port mem_rdata, input, LINE_W bits, SHALL be the memory-side read line.
REQ-017 Port mem_ready, input, 1 bit, SHALL be the memory-side completion.
REQ-018 Port grant_id, output, clog2(NUM_CH) bits (minimum 1), SHALL be the index of the channel currently or last served.
REQ-019 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, MEM, RESP.
REQ-021 In IDLE, a channel SHALL be requesting when ch_read[i] | ch_write[i] is high.
REQ-022 In IDLE, if any channel is requesting, the arbiter SHALL pick a winner, register its address, write data, operation and index, and enter MEM on the next edge.
REQ-023 In round-robin mode, the search SHALL start at (last_grant+1) mod NUM_CH and wrap around.
REQ-024 In round-robin mode, last_grant SHALL update to the winner.
REQ-025 In fixed-priority mode, the winner SHALL be the lowest-index requesting channel.
REQ-026 If a channel asserts read and write together, the arbiter SHALL treat the request as a write.
REQ-027 In MEM, mem_read or mem_write (exactly one, from the latched operation) SHALL be held high until mem_ready is sampled high.
REQ-028 In MEM, mem_addr and mem_wdata SHALL be held stable at the latched values.
REQ-029 On the edge where mem_ready is high in MEM, the arbiter SHALL:
  - capture mem_rdata into ch_rdata (reads only; ch_rdata holds its value on writes);
  - deassert mem_read and mem_write;
  - enter RESP.
REQ-030 In RESP, ch_ready[grant] SHALL be high for exactly one cycle, all other ch_ready bits SHALL be low, and the FSM SHALL return to IDLE.
REQ-031 Latency SHALL be:
  - request seen in IDLE at cycle t -> mem request high at t+1;
  - mem_ready high at cycle m -> ch_ready at m+1;
  - minimum 3 cycles per transaction.
REQ-032 No new arbitration SHALL occur outside IDLE; requests arriving in MEM or RESP SHALL wait.
REQ-033 A channel that drops its request during MEM SHALL still receive its ch_ready pulse.
REQ-034 mem_ready sampled in IDLE or RESP SHALL be ignored.
REQ-035 In round-robin mode with all NUM_CH channels requesting continuously, every channel SHALL be served within NUM_CH consecutive transactions.
REQ-036 With NUM_CH=1, the block SHALL behave as a registered pass-through with the same latency.

Reset
REQ-037 On rst_n low, regardless of state or any in-flight transaction, the block SHALL immediately:
  - enter IDLE;
  - drive mem_read, mem_write, ch_ready, busy to 0;
  - clear mem_addr, mem_wdata, ch_rdata and grant_id to 0;
  - set last_grant to NUM_CH-1, so ch0 wins first.
REQ-038 An in-flight transaction interrupted by reset SHALL be abandoned, with no ch_ready pulse after release.

Verification
REQ-039 Single read: ch_read=2'b01, addr 0x0000040, mem_ready after 4 cycles with rdata 0xA5..A5 -> mem_read high for 4 cycles, then ch_rdata=0xA5..A5 and ch_ready=2'b01 for one cycle.
REQ-040 Round-robin contention: both channels request continuously, NUM_CH=2 -> grant sequence 0,1,0,1; each ch_ready pulses once per grant.
REQ-041 Fixed priority (ARB_MODE=1): ch0 and ch1 request continuously -> ch1 is never granted while ch0 requests; ch1 is granted in the first IDLE after ch0 drops.
REQ-042 Write path: ch1 writes addr 0x1234567 with data 0x0F..0F, and ch_read[1] is asserted simultaneously -> mem_write=1 and mem_read=0, mem_addr=0x1234567, mem_wdata=0x0F..0F; ch_rdata is unchanged.
REQ-043 Reset mid-MEM: rst_n pulled low while mem_read=1 -> all outputs 0 in the same cycle, and no ch_ready after release.
REQ-044 Spurious ready: mem_ready=1 while IDLE with no requests -> no state change and ch_ready stays 0.
